// File: rtl/ristretto_exe_stage_pkg.sv
// ristretto_exe_stage_pkg: shared execute-stage types for the BJU and redirect controller
package ristretto_exe_stage_pkg;
  typedef enum logic [1:0] {
    BJU_NONE   = 2'b00,
    BJU_BRANCH = 2'b01,
    BJU_JAL    = 2'b10,
    BJU_JALR   = 2'b11
  } bju_op_t;
  typedef enum logic [1:0] {RC_IDLE, RC_REDIRECT, RC_FLUSH, RC_TRAP} rc_state_t;
  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
  function automatic logic bju_act(logic [1:0] op, logic taken);
    return op == BJU_JAL || op == BJU_JALR || (op == BJU_BRANCH && taken);
  endfunction
endpackage

// File: rtl/ristretto_redirect_ctrl_if.sv
// ristretto_redirect_ctrl_if: BJU result, IF redirect and trap request signals around the redirect controller
interface ristretto_redirect_ctrl_if #(
  parameter int DataWidth = 32
);
  logic                 rc_valid_i;
  logic                 rc_ready_o;
  logic [1:0]           rc_op_i;
  logic                 rc_branch_taken_i;
  logic                 rc_misalig_i;
  logic [DataWidth-1:0] rc_next_pc_i;
  logic [DataWidth-1:0] rc_pc_i;
  logic                 if_redirect_valid_o;
  logic                 if_redirect_ready_i;
  logic [DataWidth-1:0] if_redirect_pc_o;
  logic                 pipe_flush_o;
  logic                 exe_stall_o;
  logic                 trap_valid_o;
  logic [3:0]           trap_cause_o;
  logic [DataWidth-1:0] trap_epc_o;
  logic                 trap_ack_i;
  modport slave (
    input  rc_valid_i, rc_op_i, rc_branch_taken_i, rc_misalig_i, rc_next_pc_i, rc_pc_i,
    input  if_redirect_ready_i, trap_ack_i,
    output rc_ready_o, if_redirect_valid_o, if_redirect_pc_o, pipe_flush_o, exe_stall_o,
    output trap_valid_o, trap_cause_o, trap_epc_o
  );
  modport master (
    output rc_valid_i, rc_op_i, rc_branch_taken_i, rc_misalig_i, rc_next_pc_i, rc_pc_i,
    output if_redirect_ready_i, trap_ack_i,
    input  rc_ready_o, if_redirect_valid_o, if_redirect_pc_o, pipe_flush_o, exe_stall_o,
    input  trap_valid_o, trap_cause_o, trap_epc_o
  );
endinterface

// File: rtl/ristretto_redirect_ctrl.sv
// ristretto_redirect_ctrl: turns resolved BJU results into IF redirects, pipeline squashes and misaligned-target traps
module ristretto_redirect_ctrl
  import ristretto_exe_stage_pkg::*;
#(
  parameter int                   DataWidth   = 32,
  parameter int                   FlushCycles = 2,
  parameter logic [DataWidth-1:0] TrapVector  = 'h100
) (
  input logic                      clk_i,
  input logic                      rstn_i,
  ristretto_redirect_ctrl_if.slave rc
);
  if (FlushCycles < 0 || FlushCycles > 15) begin : g_bad_flush
    $error("FlushCycles must be within 0..15");
  end
  rc_state_t            state_q;
  logic [DataWidth-1:0] target_q;
  logic [DataWidth-1:0] epc_q;
  logic [3:0]           cnt_q;
  // Control FSM: accept a result in IDLE, then redirect, squash, or trap before redirecting to the vector
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= RC_IDLE;
      target_q <= '0;
      epc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        RC_IDLE:
          if (rc.rc_valid_i && bju_act(rc.rc_op_i, rc.rc_branch_taken_i)) begin
            if (rc.rc_misalig_i) begin
              epc_q   <= rc.rc_pc_i;
              state_q <= RC_TRAP;
            end else begin
              target_q <= rc.rc_next_pc_i;
              state_q  <= RC_REDIRECT;
            end
          end
        RC_REDIRECT:
          if (rc.if_redirect_ready_i) begin
            cnt_q   <= 4'(FlushCycles);
            state_q <= FlushCycles == 0 ? RC_IDLE : RC_FLUSH;
          end
        RC_FLUSH: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RC_IDLE;
        end
        RC_TRAP:
          if (rc.trap_ack_i) begin
            target_q <= TrapVector;
            state_q  <= RC_REDIRECT;
          end
      endcase
    end
  end
  assign rc.rc_ready_o          = state_q == RC_IDLE;
  assign rc.if_redirect_valid_o = state_q == RC_REDIRECT;
  assign rc.if_redirect_pc_o    = state_q == RC_REDIRECT ? target_q : '0;
  assign rc.pipe_flush_o        = state_q != RC_IDLE;
  assign rc.exe_stall_o         = state_q != RC_IDLE;
  assign rc.trap_valid_o        = state_q == RC_TRAP;
  assign rc.trap_cause_o        = state_q == RC_TRAP ? EXC_INSTR_MISALIGNED : '0;
  assign rc.trap_epc_o          = state_q == RC_TRAP ? epc_q : '0;
endmodule

// File: tb/tb_ristretto_redirect_ctrl.sv
// tb_ristretto_redirect_ctrl: cycle-vector table plus scoreboard check of the redirect controller
module tb_ristretto_redirect_ctrl;
  typedef struct {
    logic        rstn, valid;
    logic [1:0]  op;
    logic        taken, mis;
    logic [31:0] npc, pc;
    logic        rdy_in, ack;
    logic        e_rdy, e_rv;
    logic [31:0] e_rpc;
    logic        e_fl, e_tv;
    logic [31:0] e_epc;
  } vec_t;
  typedef struct {
    logic        rdy, rv;
    logic [31:0] rpc;
    logic        fl, tv;
    logic [31:0] epc;
  } exp_t;
  logic clk = 0;
  logic rstn = 0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[$];
  exp_t sb[$];
  ristretto_redirect_ctrl_if #(.DataWidth(32)) bus ();
  ristretto_redirect_ctrl #(.DataWidth(32), .FlushCycles(2), .TrapVector(32'h100)) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .rc(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  function automatic void add(input logic rs, v, input logic [1:0] op, input logic tk, ms,
                              input logic [31:0] npc, pc, input logic ri, ak,
                              input logic er, erv, input logic [31:0] erpc,
                              input logic efl, etv, input logic [31:0] eepc);
    vecs.push_back('{rs, v, op, tk, ms, npc, pc, ri, ak, er, erv, erpc, efl, etv, eepc});
  endfunction
  task automatic drive(input logic rs, v, input logic [1:0] op, input logic tk, ms,
                       input logic [31:0] npc, pc, input logic ri, ak);
    rstn = rs;
    bus.rc_valid_i = v;
    bus.rc_op_i = op;
    bus.rc_branch_taken_i = tk;
    bus.rc_misalig_i = ms;
    bus.rc_next_pc_i = npc;
    bus.rc_pc_i = pc;
    bus.if_redirect_ready_i = ri;
    bus.trap_ack_i = ak;
  endtask
  initial begin
    exp_t e;
    int k;
    int cnt;
    logic seen;
    // reset state, then test 1: JAL with IF ready
    add(1,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0);
    add(1,1,2,0,0,32'h2000,32'h1000,1,0,   1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,1,32'h2000,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 1,0,0,0,0,0);
    // test 2: not-taken branch and op none, misaligned flag ignored
    add(1,1,1,0,1,32'h1008,32'h1004,1,1,   1,0,0,0,0,0);
    add(1,1,0,1,1,32'h77,32'h70,1,1,       1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0);
    // test 3: taken branch, IF back-pressure 5 cycles, stray trap_ack ignored
    add(1,1,1,1,0,32'h40,32'h30,0,0,       1,0,0,0,0,0);
    for (int i = 0; i < 5; i++) add(1,0,0,0,0,0,0,0,1, 0,1,32'h40,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,1,32'h40,1,0,0);
    add(1,0,0,0,0,0,0,0,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,0,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0);
    // test 4: misaligned JALR traps, then redirect to the trap vector; stray IF ready ignored
    add(1,1,3,0,1,32'h1006,32'h1004,1,0,   1,0,0,0,0,0);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0,0,0,1,0, 0,0,0,1,1,32'h1004);
    add(1,0,0,0,0,0,0,1,1,                 0,0,0,1,1,32'h1004);
    add(1,0,0,0,0,0,0,1,0,                 0,1,32'h100,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 1,0,0,0,0,0);
    // test 5: reset during REDIRECT, then a fresh JAL
    add(1,1,2,0,0,32'h3000,32'h2f00,0,0,   1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,                 0,1,32'h3000,1,0,0);
    add(0,0,0,0,0,0,0,0,0,                 0,1,32'h3000,1,0,0);
    add(1,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0);
    add(1,1,2,0,0,32'h3100,32'h3000,1,0,   1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,1,32'h3100,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 1,0,0,0,0,0);
    // test 6: second JAL held valid while busy is taken only once IDLE
    add(1,1,2,0,0,32'h4000,32'h3f00,1,0,   1,0,0,0,0,0);
    add(1,1,2,0,0,32'h5000,32'h4000,1,0,   0,1,32'h4000,1,0,0);
    add(1,1,2,0,0,32'h5000,32'h4000,1,0,   0,0,0,1,0,0);
    add(1,1,2,0,0,32'h5000,32'h4000,1,0,   0,0,0,1,0,0);
    add(1,1,2,0,0,32'h5000,32'h4000,1,0,   1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,1,32'h5000,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 0,0,0,1,0,0);
    add(1,0,0,0,0,0,0,1,0,                 1,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rstn, vecs[i].valid, vecs[i].op, vecs[i].taken, vecs[i].mis,
            vecs[i].npc, vecs[i].pc, vecs[i].rdy_in, vecs[i].ack);
      sb.push_back('{vecs[i].e_rdy, vecs[i].e_rv, vecs[i].e_rpc, vecs[i].e_fl, vecs[i].e_tv, vecs[i].e_epc});
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_ready", i), 32'(bus.rc_ready_o), 32'(e.rdy));
      chk($sformatf("v%0d_rvalid", i), 32'(bus.if_redirect_valid_o), 32'(e.rv));
      chk($sformatf("v%0d_rpc", i), bus.if_redirect_pc_o, e.rpc);
      chk($sformatf("v%0d_flush", i), 32'(bus.pipe_flush_o), 32'(e.fl));
      chk($sformatf("v%0d_stall", i), 32'(bus.exe_stall_o), 32'(e.fl));
      chk($sformatf("v%0d_tvalid", i), 32'(bus.trap_valid_o), 32'(e.tv));
      chk($sformatf("v%0d_tcause", i), 32'(bus.trap_cause_o), 32'h0);
      chk($sformatf("v%0d_epc", i), bus.trap_epc_o, e.epc);
    end
    // hand sequence: random back-pressure, PC stability and exact flush length
    @(negedge clk);
    drive(1,1,2,0,0,32'h6000,32'h5f00,0,0);
    @(negedge clk);
    drive(1,0,0,0,0,0,0,0,0);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      #1;
      seen = bus.if_redirect_valid_o;
      if (!seen) @(negedge clk);
    end
    chk("hs_valid_rise", 32'(seen), 32'h1);
    k = $urandom_range(1, 4);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      #1;
      chk("hs_hold_valid", 32'(bus.if_redirect_valid_o), 32'h1);
      chk("hs_hold_pc", bus.if_redirect_pc_o, 32'h6000);
      chk("hs_hold_stall", 32'(bus.exe_stall_o), 32'h1);
    end
    @(negedge clk);
    bus.if_redirect_ready_i = 1;
    #1;
    chk("hs_pc_at_handshake", bus.if_redirect_pc_o, 32'h6000);
    @(negedge clk);
    bus.if_redirect_ready_i = 0;
    cnt = 0;
    #1;
    for (int i = 0; i < 20 && !bus.rc_ready_o; i++) begin
      if (bus.pipe_flush_o && !bus.if_redirect_valid_o) cnt++;
      @(negedge clk);
      #1;
    end
    chk("hs_back_idle", 32'(bus.rc_ready_o), 32'h1);
    chk("hs_flush_len", 32'(cnt), 32'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
